// File: rtl/lfsr_rng_bank.sv
// rtl/lfsr_rng_bank.sv - multi-channel Fibonacci LFSR bank with warm-up and valid/ready output
module lfsr_rng_bank #(
  parameter int          NUM_BITS      = 32,
  parameter int          NUM_CHAN      = 4,
  parameter logic [31:0] SEED_STRIDE   = 32'h9E3779B9,
  parameter int          WARMUP_CYCLES = 16
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic [NUM_BITS-1:0]          i_Seed_Data,
  input  logic                         i_Seed_DV,
  output logic [NUM_CHAN*NUM_BITS-1:0] o_LFSR_Data,
  output logic                         o_Valid,
  input  logic                         i_Ready,
  output logic [NUM_CHAN-1:0]          o_LFSR_Done,
  output logic                         o_Busy
);

  localparam int W  = NUM_BITS;
  localparam int DW = NUM_CHAN * NUM_BITS;

  // Maximal-length tap masks, one bit set per feedback tap.
  localparam logic [31:0] TAPS =
    (NUM_BITS == 4)  ? 32'h0000_0009 :
    (NUM_BITS == 8)  ? 32'h0000_00B8 :
    (NUM_BITS == 16) ? 32'h0000_D008 :
    (NUM_BITS == 24) ? 32'h00E1_0000 :
                       32'h8020_0003;

  localparam logic [15:0] WARMUP_LAST =
    (WARMUP_CYCLES > 0) ? 16'(WARMUP_CYCLES - 1) : 16'd0;

  if (!(NUM_BITS == 4 || NUM_BITS == 8 || NUM_BITS == 16 ||
        NUM_BITS == 24 || NUM_BITS == 32)) begin : g_bad_bits
    $error("lfsr_rng_bank: NUM_BITS must be one of 4, 8, 16, 24, 32");
  end
  if (NUM_CHAN < 1 || NUM_CHAN > 16) begin : g_bad_chan
    $error("lfsr_rng_bank: NUM_CHAN must be in 1..16");
  end
  if (WARMUP_CYCLES < 0 || WARMUP_CYCLES > 65535) begin : g_bad_warmup
    $error("lfsr_rng_bank: WARMUP_CYCLES must be in 0..65535");
  end

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_e;

  state_e              fsm_q;
  logic [DW-1:0]       lfsr_q;
  logic [DW-1:0]       seed_q;
  logic [15:0]         cnt_q;
  logic                valid_q;
  logic                busy_q;
  logic [NUM_CHAN-1:0] done_q;

  logic [DW-1:0]       seed_d;
  logic [DW-1:0]       lfsr_d;
  logic [NUM_CHAN-1:0] hit;

  // Per-channel derived seeds, one-step successor state, and period-match flags.
  always_comb begin
    seed_d = '0;
    lfsr_d = '0;
    hit    = '0;
    for (int k = 0; k < NUM_CHAN; k++) begin
      seed_d[k*W +: W] = i_Seed_Data ^ W'(32'(k) * SEED_STRIDE);
      // All-zero would lock the register, so it is nudged to 1.
      if (seed_d[k*W +: W] == '0) seed_d[k*W +: W] = W'(1);
      lfsr_d[k*W +: W] = {lfsr_q[k*W +: W-1], ^(lfsr_q[k*W +: W] & TAPS[W-1:0])};
      hit[k] = (lfsr_d[k*W +: W] == seed_q[k*W +: W]);
    end
  end

  // Control FSM: reset/reseed load, warm-up stepping, handshake-driven stepping.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      fsm_q   <= S_RESET;
      lfsr_q  <= seed_d;
      seed_q  <= seed_d;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= '0;
    end else if (i_Seed_DV) begin
      // Reseed wins over a coinciding handshake: the word is consumed, no step.
      lfsr_q <= seed_d;
      seed_q <= seed_d;
      cnt_q  <= '0;
      done_q <= '0;
      if (WARMUP_CYCLES > 0) begin
        fsm_q   <= S_WARMUP;
        valid_q <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        fsm_q   <= S_RUN;
        valid_q <= 1'b1;
        busy_q  <= 1'b0;
      end
    end else begin
      case (fsm_q)
        S_RESET: begin
          done_q <= '0;
          cnt_q  <= '0;
          if (WARMUP_CYCLES > 0) begin
            fsm_q   <= S_WARMUP;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            fsm_q   <= S_RUN;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_WARMUP: begin
          lfsr_q <= lfsr_d;
          done_q <= hit;
          cnt_q  <= cnt_q + 16'd1;
          if (cnt_q == WARMUP_LAST) begin
            fsm_q   <= S_RUN;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (valid_q && i_Ready) begin
            lfsr_q <= lfsr_d;
            done_q <= hit;
          end else begin
            done_q <= '0;
          end
        end
        default: begin
          fsm_q   <= S_RESET;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= '0;
        end
      endcase
    end
  end

  assign o_LFSR_Data = lfsr_q;
  assign o_Valid     = valid_q;
  assign o_Busy      = busy_q;
  assign o_LFSR_Done = done_q;

endmodule

// File: tb/tb_lfsr_rng_bank.sv
// tb/tb_lfsr_rng_bank.sv - self-checking bench for lfsr_rng_bank
`timescale 1ns/1ps
module tb_lfsr_rng_bank;

  localparam logic [31:0] STRIDE = 32'h9E3779B9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // DUT A: 4-bit, 1 channel, no warm-up
  logic       a_rst, a_dv, a_rdy, a_valid, a_busy;
  logic [3:0] a_seed, a_data;
  logic [0:0] a_done;

  // DUT B: 32-bit, 4 channels, 16 warm-up steps
  logic         b_rst, b_dv, b_rdy, b_valid, b_busy;
  logic [31:0]  b_seed;
  logic [127:0] b_data;
  logic [3:0]   b_done;

  // DUT C: 4-bit, 1 channel, 2 warm-up steps
  logic       c_rst, c_dv, c_rdy, c_valid, c_busy;
  logic [3:0] c_seed, c_data;
  logic [0:0] c_done;

  lfsr_rng_bank #(.NUM_BITS(4), .NUM_CHAN(1), .SEED_STRIDE(STRIDE), .WARMUP_CYCLES(0)) u_a (
    .i_Clk(clk), .i_Rst(a_rst), .i_Seed_Data(a_seed), .i_Seed_DV(a_dv),
    .o_LFSR_Data(a_data), .o_Valid(a_valid), .i_Ready(a_rdy),
    .o_LFSR_Done(a_done), .o_Busy(a_busy));

  lfsr_rng_bank #(.NUM_BITS(32), .NUM_CHAN(4), .SEED_STRIDE(STRIDE), .WARMUP_CYCLES(16)) u_b (
    .i_Clk(clk), .i_Rst(b_rst), .i_Seed_Data(b_seed), .i_Seed_DV(b_dv),
    .o_LFSR_Data(b_data), .o_Valid(b_valid), .i_Ready(b_rdy),
    .o_LFSR_Done(b_done), .o_Busy(b_busy));

  lfsr_rng_bank #(.NUM_BITS(4), .NUM_CHAN(1), .SEED_STRIDE(STRIDE), .WARMUP_CYCLES(2)) u_c (
    .i_Clk(clk), .i_Rst(c_rst), .i_Seed_Data(c_seed), .i_Seed_DV(c_dv),
    .o_LFSR_Data(c_data), .o_Valid(c_valid), .i_Ready(c_rdy),
    .o_LFSR_Done(c_done), .o_Busy(c_busy));

  // Reference model: plain arithmetic on integers
  function automatic logic [31:0] ref_mask(input int nb);
    return (nb == 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
  endfunction

  function automatic logic [31:0] ref_next(input int nb, input logic [31:0] s);
    int   taps[4];
    int   ntaps;
    logic fb;
    case (nb)
      4:       begin taps = '{3, 0, 0, 0};     ntaps = 2; end
      8:       begin taps = '{7, 5, 4, 3};     ntaps = 4; end
      16:      begin taps = '{15, 14, 12, 3};  ntaps = 4; end
      24:      begin taps = '{23, 22, 21, 16}; ntaps = 4; end
      default: begin taps = '{31, 21, 1, 0};   ntaps = 4; end
    endcase
    fb = 1'b0;
    for (int i = 0; i < ntaps; i++) fb = fb ^ s[taps[i]];
    return ((s << 1) | {31'd0, fb}) & ref_mask(nb);
  endfunction

  function automatic logic [31:0] ref_seed(input int nb, input int k, input logic [31:0] base);
    logic [31:0] off;
    logic [31:0] v;
    off = 32'(k) * STRIDE;
    v = (base ^ off) & ref_mask(nb);
    if (v == 32'd0) v = 32'd1;
    return v;
  endfunction

  function automatic logic [127:0] ref_bank(input logic [31:0] base, input int steps);
    logic [127:0] r;
    logic [31:0]  s;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = ref_seed(32, k, base);
      for (int i = 0; i < steps; i++) s = ref_next(32, s);
      r[k*32 +: 32] = s;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; a_seed = 4'b0001; a_rdy = 1'b1; a_dv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (a_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", a_valid);
      else n_pass++;
      n_total++;
      if (a_data !== 4'b0001 || a_done !== 1'b0 || a_busy !== 1'b0)
        $display("FAIL reset_data: got data=%b done=%b busy=%b want 0001/0/0", a_data, a_done, a_busy);
      else n_pass++;
    end
    a_rst = 1'b0;
    tick();
    n_total++;
    if (a_valid !== 1'b1 || a_data !== 4'b0001)
      $display("FAIL reset_exit: got valid=%b data=%b want 1/0001", a_valid, a_data);
    else n_pass++;
  endtask

  task automatic test_sequence();
    logic [3:0] words [7];
    words = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101, 4'b1010};
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (a_valid !== 1'b1 || a_data !== words[i])
        $display("FAIL seq_word%0d: got valid=%b data=%b want 1/%b", i, a_valid, a_data, words[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_period();
    logic [31:0] m;
    int pulses;
    a_rst = 1'b1; a_seed = 4'b0001; a_rdy = 1'b1;
    tick(); tick();
    n_total++;
    if (a_done !== 1'b0) $display("FAIL period_reset_done: got %b want 0", a_done);
    else n_pass++;
    a_rst = 1'b0;
    tick();
    m = 32'd1;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      m = ref_next(4, m);
      n_total++;
      if (a_data !== m[3:0] || a_done !== 1'(m == 32'd1))
        $display("FAIL period_step%0d: got data=%b done=%b want %b/%b", i, a_data, a_done, m[3:0], (m == 32'd1));
      else n_pass++;
      if (a_done === 1'b1) pulses++;
    end
    n_total++;
    if (pulses != 3) $display("FAIL period_pulses: got %0d want 3", pulses);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] m;
    int r;
    a_rst = 1'b1; a_seed = 4'b0001; a_rdy = 1'b1;
    tick();
    a_rst = 1'b0;
    tick();
    tick();
    n_total++;
    if (a_data !== 4'b0011) $display("FAIL bp_first: got %b want 0011", a_data);
    else n_pass++;
    a_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if (a_data !== 4'b0011 || a_valid !== 1'b1)
        $display("FAIL bp_hold%0d: got data=%b valid=%b want 0011/1", i, a_data, a_valid);
      else n_pass++;
    end
    a_rdy = 1'b1;
    tick();
    n_total++;
    if (a_data !== 4'b0111) $display("FAIL bp_resume: got %b want 0111", a_data);
    else n_pass++;
    m = 32'h7;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 1));
      a_rdy = (r != 0);
      tick();
      if (r != 0) m = ref_next(4, m);
      n_total++;
      if (a_data !== m[3:0] || a_valid !== 1'b1 || a_done !== 1'(r != 0 && m == 32'd1))
        $display("FAIL bp_rand%0d: got data=%b valid=%b done=%b want %b/1/%b",
                 i, a_data, a_valid, a_done, m[3:0], (r != 0 && m == 32'd1));
      else n_pass++;
    end
    a_rdy = 1'b1;
  endtask

  task automatic wait_b_valid(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (b_valid === 1'b1) break;
      if (b_busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic test_warmup_zero_seed();
    logic [127:0] exp;
    int busy_cycles;
    logic distinct;
    b_rst = 1'b1; b_seed = 32'd0; b_rdy = 1'b0; b_dv = 1'b0;
    tick(); tick();
    n_total++;
    if (b_data[31:0] !== 32'd1) $display("FAIL wu_ch0_seed: got %h want 00000001", b_data[31:0]);
    else n_pass++;
    exp = ref_bank(32'd0, 0);
    n_total++;
    if (b_data !== exp) $display("FAIL wu_seeds: got %h want %h", b_data, exp);
    else n_pass++;
    b_rst = 1'b0;
    wait_b_valid(busy_cycles);
    n_total++;
    if (busy_cycles != 16 || b_valid !== 1'b1 || b_busy !== 1'b0)
      $display("FAIL wu_length: got busy_cycles=%0d valid=%b busy=%b want 16/1/0", busy_cycles, b_valid, b_busy);
    else n_pass++;
    exp = ref_bank(32'd0, 16);
    n_total++;
    if (b_data !== exp) $display("FAIL wu_data: got %h want %h", b_data, exp);
    else n_pass++;
    distinct = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (b_data[i*32 +: 32] === b_data[j*32 +: 32]) distinct = 1'b0;
    n_total++;
    if (distinct !== 1'b1) $display("FAIL wu_distinct: got %h want four distinct channels", b_data);
    else n_pass++;
    tick(); tick(); tick();
    n_total++;
    if (b_data !== exp || b_valid !== 1'b1)
      $display("FAIL wu_stall_hold: got %h valid=%b want %h/1", b_data, b_valid, exp);
    else n_pass++;
  endtask

  task automatic test_reseed_handshake();
    logic [31:0] m;
    int n;
    c_rst = 1'b1; c_seed = 4'b0001; c_rdy = 1'b1; c_dv = 1'b0;
    tick();
    c_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (c_valid === 1'b1) break;
    end
    m = ref_next(4, ref_next(4, 32'd1));
    n_total++;
    if (c_valid !== 1'b1 || c_data !== m[3:0])
      $display("FAIL rs_first: got valid=%b data=%b want 1/%b", c_valid, c_data, m[3:0]);
    else n_pass++;
    n = int'($urandom_range(1, 4));
    for (int i = 0; i < n; i++) begin
      tick();
      m = ref_next(4, m);
      n_total++;
      if (c_data !== m[3:0]) $display("FAIL rs_run%0d: got %b want %b", i, c_data, m[3:0]);
      else n_pass++;
    end
    c_dv = 1'b1; c_seed = 4'b0001;
    tick();
    c_dv = 1'b0;
    n_total++;
    if (c_valid !== 1'b0 || c_busy !== 1'b1 || c_data !== 4'b0001 || c_done !== 1'b0)
      $display("FAIL rs_load: got valid=%b busy=%b data=%b done=%b want 0/1/0001/0", c_valid, c_busy, c_data, c_done);
    else n_pass++;
    tick();
    n_total++;
    if (c_valid !== 1'b0 || c_data !== 4'b0011 || c_done !== 1'b0)
      $display("FAIL rs_warm: got valid=%b data=%b done=%b want 0/0011/0", c_valid, c_data, c_done);
    else n_pass++;
    tick();
    n_total++;
    if (c_valid !== 1'b1 || c_data !== 4'b0111 || c_done !== 1'b0)
      $display("FAIL rs_next: got valid=%b data=%b done=%b want 1/0111/0", c_valid, c_data, c_done);
    else n_pass++;
  endtask

  task automatic test_reset_priority();
    logic [31:0]  sa, sb;
    logic [127:0] exp;
    int busy_cycles;
    sa = $urandom;
    sb = $urandom;
    if (sb == sa) sb = ~sa;
    b_rst = 1'b1; b_seed = sa; b_dv = 1'b0; b_rdy = 1'b1;
    tick();
    b_rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_total++;
    if (b_busy !== 1'b1) $display("FAIL pri_midwarm: got busy=%b want 1", b_busy);
    else n_pass++;
    b_rst = 1'b1; b_dv = 1'b1; b_seed = sb;
    tick();
    exp = ref_bank(sb, 0);
    n_total++;
    if (b_data !== exp || b_busy !== 1'b0 || b_valid !== 1'b0)
      $display("FAIL pri_load: got %h busy=%b valid=%b want %h/0/0", b_data, b_busy, b_valid, exp);
    else n_pass++;
    b_rst = 1'b0; b_dv = 1'b0;
    wait_b_valid(busy_cycles);
    n_total++;
    if (busy_cycles != 16) $display("FAIL pri_restart: got busy_cycles=%0d want 16", busy_cycles);
    else n_pass++;
    exp = ref_bank(sb, 16);
    n_total++;
    if (b_data !== exp) $display("FAIL pri_data: got %h want %h", b_data, exp);
    else n_pass++;
  endtask

  initial begin
    a_rst = 1'b1; a_dv = 1'b0; a_rdy = 1'b0; a_seed = 4'b0001;
    b_rst = 1'b1; b_dv = 1'b0; b_rdy = 1'b0; b_seed = 32'd0;
    c_rst = 1'b1; c_dv = 1'b0; c_rdy = 1'b0; c_seed = 4'b0001;
    test_reset();
    test_sequence();
    test_period();
    test_backpressure();
    test_warmup_zero_seed();
    test_reseed_handshake();
    test_reset_priority();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_bank.md
Name: lfsr_rng_bank

Overview:
Multi-channel pseudo-random source for the MCMC samplers. It holds NUM_CHAN independent maximal-length Fibonacci LFSRs of NUM_BITS each, all seeded from one seed word with a per-channel decorrelation offset. The block discards a configurable warm-up run after every (re)seed, then presents all channels as one word on a valid/ready stream. Each channel flags completion of its full period.

Parameters:
- NUM_BITS, 32: LFSR width. Legal values are 4, 8, 16, 24, 32; any other value is an elaboration error.
- NUM_CHAN, 4: number of independent LFSR channels, 1..16.
- SEED_STRIDE, 32'h9E3779B9: per-channel seed offset constant.
- WARMUP_CYCLES, 16: steps discarded after reset or reseed, 0..65535.

Ports:
- i_Clk  in  1  clock
- i_Rst  in  1  synchronous active-high reset; also loads seeds from i_Seed_Data
- i_Seed_Data  in  NUM_BITS  base seed
- i_Seed_DV  in  1  one-cycle reseed strobe, sampled when i_Rst=0
- o_LFSR_Data  out  NUM_CHAN*NUM_BITS  channel k occupies bits [k*NUM_BITS +: NUM_BITS]
- o_Valid  out  1  o_LFSR_Data is a fresh post-warm-up word
- i_Ready  in  1  consumer accepts the word when o_Valid=1
- o_LFSR_Done  out  NUM_CHAN  per-channel one-cycle period-complete pulse
- o_Busy  out  1  warm-up in progress

Behaviour:
- Clock and reset: single clock i_Clk. Reset i_Rst is synchronous and active-high.
- Seed derivation: seed_k = i_Seed_Data XOR (k*SEED_STRIDE)[NUM_BITS-1:0], so channel 0 uses the raw seed. A derived seed of 0 is replaced by 1, because all-zero is the lock-up state. Each channel stores its seed_k in a seed register for period detection.
- Step: state <= {state[NUM_BITS-2:0], fb}, where fb is the XOR of these tap bits:
  - 4: {3,0}
  - 8: {7,5,4,3}
  - 16: {15,14,12,3}
  - 24: {23,22,21,16}
  - 32: {31,21,1,0}
- All channels always step together.
- FSM states:
  - RESET: i_Rst=1. Loads state and seed registers with seed_k, clears the warm-up counter. Outputs: o_Valid=0, o_Busy=0, o_LFSR_Done=0, o_LFSR_Data=seeds.
  - WARMUP: steps every cycle and counts to WARMUP_CYCLES. o_Busy=1, o_Valid=0. Goes to RUN after the WARMUP_CYCLES-th step.
  - RUN: o_Valid=1 and o_LFSR_Data = current states. Steps only on a cycle where o_Valid & i_Ready. Holds otherwise, with data stable while stalled.
- Exit from RESET: when i_Rst deasserts, the FSM goes to WARMUP if WARMUP_CYCLES>0, else to RUN. With WARMUP_CYCLES=0, o_Valid=1 in the first cycle after reset and o_LFSR_Data equals the seeds.
- Reseed: i_Seed_DV=1 in any state (i_Rst=0) loads seed_k into the state and seed registers, clears the counter, and enters WARMUP (or RUN if WARMUP_CYCLES=0).
  - o_Valid is 0 in the following cycle when WARMUP_CYCLES>0.
  - If i_Seed_DV coincides with a handshake, the reseed wins. The presented word counts as consumed, and no step is applied.
- i_Rst has priority over i_Seed_DV.
- Period detection: o_LFSR_Done[k] is registered. It is 1 for exactly one cycle after a step whose result equals seed_k. Warm-up steps count toward the period, so the pulse occurs every 2^NUM_BITS-1 steps. A reseed never raises Done by itself.
- Outputs are registered; there are no combinational paths from i_Ready to outputs.

Test Plan:
- Reset sequence and channel 0 values: NUM_BITS=4, NUM_CHAN=1, WARMUP_CYCLES=0, seed 4'b0001, reset for 5 cycles, i_Ready=1.
  - During reset: o_Valid=0 and o_LFSR_Data=0001.
  - Then accepted words are 0001, 0011, 0111, 1111, 1110, 1101, 1010.
- Period wrap: same setup, i_Ready=1 continuously. o_LFSR_Done[0] pulses exactly once per 15 accepts, in the cycle o_LFSR_Data returns to 0001, and never at reset.
- Backpressure: same setup, toggle i_Ready 1,0,0,1. Data holds 0011 across the two stall cycles; the next accepted word is 0111; no word is skipped or duplicated.
- Warm-up and zero seed: NUM_BITS=32, NUM_CHAN=4, WARMUP_CYCLES=16, seed 0.
  - Channel 0 is seeded with 1.
  - o_Busy=1 and o_Valid=0 for 16 cycles, then o_Valid=1.
  - Channel 0 word equals the 16th LFSR state from 1.
  - All four channels differ.
- Mid-stream reseed with handshake: NUM_BITS=4, NUM_CHAN=1, WARMUP_CYCLES=2; assert i_Seed_DV with seed 0001 during a RUN handshake.
  - o_Valid=0 for 2 cycles.
  - The next valid word is 0111.
  - No o_LFSR_Done pulse results from the reseed.
- Reset priority: assert i_Rst and i_Seed_DV together mid-warm-up with different seeds. The seeds come from the reset path, and the warm-up count restarts from 0.
